// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared load encodings and data memory sizing
package cpu_mem_pkg;

  localparam int DEPTH_WORDS_DEF = 1024;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LW   = 3'b001,
    LD_LB   = 3'b010,
    LD_LBU  = 3'b011,
    LD_LH   = 3'b100,
    LD_LHU  = 3'b101
  } load_type_e;

  function automatic logic is_load(input logic [2:0] lt);
    return (lt == LD_LW) || (lt == LD_LB) || (lt == LD_LBU) ||
           (lt == LD_LH) || (lt == LD_LHU);
  endfunction

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - selects the loaded byte/half lane and sign/zero extends it
module load_ext
  import cpu_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*lane +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    result   = 32'h0;
    case (load_type)
      LD_LW:   result = word;
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'h0, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'h0, half_sel};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_rw.sv
// rtl/data_mem_rw.sv - M-stage data memory with byte-lane stores and W-stage load alignment
module data_mem_rw
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  mem_we,
  input  logic [31:0] wdata,
  input  logic [2:0]  load_type,
  input  logic [4:0]  dst_reg,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] rdata_w,
  output logic [4:0]  dst_reg_w,
  output logic        load_valid_w,
  output logic        misalign_w
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   wr_word;
  logic          st_mis;
  logic          ld_mis;
  logic          mis_m;
  logic          do_write;
  logic          addr_hi_unused;

  logic [31:0] rd_word_w;
  logic [1:0]  lane_w;
  logic [2:0]  ltype_w;
  logic [31:0] ext_data;

  assign lane           = addr[1:0];
  assign idx            = AW'((32'(addr[11:2])) % DEPTH_WORDS);
  assign addr_hi_unused = ^addr[31:12];

  // Store lane check and replication; unknown enable patterns count as misaligned
  always_comb begin
    st_mis  = 1'b0;
    wr_word = wdata;
    case (mem_we)
      4'b0000: st_mis = 1'b0;
      4'b1111: st_mis = (lane != 2'b00);
      4'b0011: begin st_mis = lane[1];  wr_word = {2{wdata[15:0]}}; end
      4'b1100: begin st_mis = !lane[1]; wr_word = {2{wdata[15:0]}}; end
      4'b0001: begin st_mis = (lane != 2'd0); wr_word = {4{wdata[7:0]}}; end
      4'b0010: begin st_mis = (lane != 2'd1); wr_word = {4{wdata[7:0]}}; end
      4'b0100: begin st_mis = (lane != 2'd2); wr_word = {4{wdata[7:0]}}; end
      4'b1000: begin st_mis = (lane != 2'd3); wr_word = {4{wdata[7:0]}}; end
      default: st_mis = 1'b1;
    endcase
  end

  always_comb begin
    ld_mis = 1'b0;
    case (load_type)
      LD_LW:         ld_mis = (lane != 2'b00);
      LD_LH, LD_LHU: ld_mis = lane[0];
      default:       ld_mis = 1'b0;
    endcase
  end

  assign mis_m    = st_mis | ld_mis;
  assign do_write = reset && !stall && (mem_we != 4'b0000) && !st_mis;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_we[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  // M/W register: stall holds, flush clears the control copies so rdata_w reads as 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_word_w  <= 32'h0;
      lane_w     <= 2'b00;
      ltype_w    <= LD_NONE;
      dst_reg_w  <= 5'd0;
      misalign_w <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        rd_word_w  <= 32'h0;
        lane_w     <= 2'b00;
        ltype_w    <= LD_NONE;
        dst_reg_w  <= 5'd0;
        misalign_w <= 1'b0;
      end else begin
        rd_word_w  <= mem[idx];
        lane_w     <= lane;
        ltype_w    <= is_load(load_type) ? load_type : LD_NONE;
        dst_reg_w  <= dst_reg;
        misalign_w <= mis_m;
      end
    end
  end

  load_ext u_load_ext (
    .word      (rd_word_w),
    .lane      (lane_w),
    .load_type (ltype_w),
    .result    (ext_data)
  );

  assign load_valid_w = is_load(ltype_w);
  assign rdata_w      = misalign_w ? 32'h0 : ext_data;

endmodule
